// File: rtl/referee_egress.sv
// referee_egress: round-robin drain of four destination FIFOs onto one
// valid/ready egress port, with per-word DEST consistency check.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   almost_empty_signal per-FIFO "do not pop" flags
//   fifo_data           FIFO i read data on [i*LINE_SIZE +: LINE_SIZE]
//   pop_signal          one-hot, single-cycle pop strobe per grant
//   out_valid/out_data  egress word, held until out_ready
//   out_ready           downstream accept
//   fwd_count           words accepted downstream (wrapping)
//   drop_count          words dropped on DEST mismatch (saturating)
module referee_egress #(
    parameter int LINE_SIZE  = 12,
    parameter int CLASS_BITS = 2,
    parameter int DEST_BITS  = 2,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             almost_empty_signal,
    input  logic [4*LINE_SIZE-1:0] fifo_data,
    output logic [3:0]             pop_signal,
    output logic                   out_valid,
    output logic [LINE_SIZE-1:0]   out_data,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       fwd_count,
    output logic [CNT_W-1:0]       drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           rr_q;
    logic [1:0]           gnt_q;
    logic [3:0]           pop_q;
    logic                 valid_q;
    logic [LINE_SIZE-1:0] data_q;
    logic [CNT_W-1:0]     fwd_q;
    logic [CNT_W-1:0]     drop_q;

    logic [1:0]           gnt_d;
    logic                 any_d;
    logic [1:0]           idx;
    logic [LINE_SIZE-1:0] word;
    logic [DEST_BITS-1:0] dest;
    logic                 match;

    // Search starts one past the last grant so every FIFO gets a turn.
    always_comb begin
        gnt_d = rr_q;
        any_d = 1'b0;
        idx   = rr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!any_d && !almost_empty_signal[idx]) begin
                any_d = 1'b1;
                gnt_d = idx;
            end
        end
    end

    assign word  = fifo_data[gnt_q*LINE_SIZE +: LINE_SIZE];
    assign dest  = word[LINE_SIZE-CLASS_BITS-1 -: DEST_BITS];
    assign match = (dest == DEST_BITS'(gnt_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 2'd3;
            gnt_q   <= 2'd0;
            pop_q   <= 4'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            fwd_q   <= '0;
            drop_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_d) begin
                        pop_q   <= 4'b0001 << gnt_d;
                        gnt_q   <= gnt_d;
                        rr_q    <= gnt_d;
                        state_q <= POP;
                    end
                end
                POP: begin
                    pop_q   <= 4'd0;
                    state_q <= CAP;
                end
                CAP: begin
                    if (match) begin
                        data_q  <= word;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        if (drop_q != '1)
                            drop_q <= drop_q + CNT_W'(1);
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    // A new pop is only issued once the held word leaves.
                    if (out_ready) begin
                        fwd_q   <= fwd_q + CNT_W'(1);
                        valid_q <= 1'b0;
                        if (any_d) begin
                            pop_q   <= 4'b0001 << gnt_d;
                            gnt_q   <= gnt_d;
                            rr_q    <= gnt_d;
                            state_q <= POP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pop_signal = pop_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign fwd_count  = fwd_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_referee_egress.sv
// tb_referee_egress: scoreboard bench for referee_egress.
// FIFO model, expected pop/data queues, negedge monitor.
module tb_referee_egress;

    localparam int LS = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    ae = 4'b1111;
    logic [4*LS-1:0] fdata;
    logic [3:0]    pop;
    logic          ov;
    logic [LS-1:0] od;
    logic          ordy = 1'b0;
    logic [7:0]    fwd;
    logic [7:0]    drop;

    logic [LS-1:0] rd [4] = '{default: '0};
    logic [LS-1:0] fq [4][$];
    int            exp_pop[$];
    logic [LS-1:0] exp_data[$];

    int total = 0;
    int bad = 0;
    int phase = 0;
    int exp_fwd = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    assign fdata = {rd[3], rd[2], rd[1], rd[0]};

    referee_egress dut (
        .clk                 (clk),
        .reset               (reset),
        .almost_empty_signal (ae),
        .fifo_data           (fdata),
        .pop_signal          (pop),
        .out_valid           (ov),
        .out_data            (od),
        .out_ready           (ordy),
        .fwd_count           (fwd),
        .drop_count          (drop)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: data popped in cycle N is on fifo_data in N+1.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (pop[i] && fq[i].size() > 0)
                rd[i] <= fq[i].pop_front();
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            ae[i] <= (fq[i].size() == 0);
    end

    // Monitor: sampled at negedge, away from the active edge.
    initial begin
        int  cyc;
        int  last_pop;
        int  mon_fwd;
        bit  prev_ov;
        bit  pend;
        bit  p6_seen;
        cyc = 0; last_pop = -100; mon_fwd = 0;
        prev_ov = 0; pend = 0; p6_seen = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                mon_fwd = 0;
                pend    = 0;
                prev_ov = 0;
            end else begin
                if (pend)
                    chk("fwd_cnt", {24'd0, fwd}, {24'd0, mon_fwd[7:0]});
                pend = 0;
                if (pop != 4'd0) begin
                    chk("pop_onehot", {31'd0, $onehot(pop)}, 1);
                    if (exp_pop.size() == 0)
                        chk("pop_extra", {28'd0, pop}, 0);
                    else
                        chk("pop_idx", {28'd0, pop}, 32'd1 << exp_pop.pop_front());
                    if (phase == 6) begin
                        if (p6_seen)
                            chk("pop_rate", cyc - last_pop, 3);
                        p6_seen = 1;
                    end
                    last_pop = cyc;
                end
                if (ov && !prev_ov)
                    chk("latency", cyc - last_pop, 2);
                if (ov && ordy) begin
                    if (exp_data.size() == 0)
                        chk("data_extra", {20'd0, od}, 0);
                    else
                        chk("data", {20'd0, od}, {20'd0, exp_data.pop_front()});
                    mon_fwd++;
                    pend = 1;
                end
                prev_ov = ov;
            end
        end
    end

    task automatic push(input int f, input logic [LS-1:0] w);
        logic [1:0] fi;
        fi = f[1:0];
        fq[f].push_back(w);
        exp_pop.push_back(f);
        if (w[9:8] == fi) begin
            exp_data.push_back(w);
            exp_fwd = (exp_fwd + 1) % 256;
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_pop.size() != 0 || exp_data.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, n < budget}, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov && n < budget);
        chk("ov_timeout", {31'd0, ov}, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pop"},  {28'd0, pop}, 0);
        chk({tag, "_ov"},   {31'd0, ov}, 0);
        chk({tag, "_data"}, {20'd0, od}, 0);
        chk({tag, "_fwd"},  {24'd0, fwd}, 0);
        chk({tag, "_drop"}, {24'd0, drop}, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Round robin over all four FIFOs
        phase = 2;
        ordy  = 1'b1;
        push(0, 12'h0A0);
        push(1, 12'h1A1);
        push(2, 12'h2A2);
        push(3, 12'h3A3);
        push(0, 12'h0A4);
        drain(200);
        chk("t2_fwd", {24'd0, fwd}, exp_fwd);

        // Async reset while holding a word
        phase = 1;
        ordy  = 1'b0;
        push(1, 12'h1A7);
        wait_ov(20);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("rst");
        exp_pop.delete();
        exp_data.delete();
        exp_fwd  = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ordy  = 1'b1;
        push(0, 12'h0D0);
        push(2, 12'h2D2);
        push(3, 12'h3D3);
        drain(200);

        // Backpressure
        phase = 3;
        ordy  = 1'b0;
        push(2, 12'h2A5);
        wait_ov(20);
        push(0, 12'h0B1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_ov",   {31'd0, ov}, 1);
            chk("bp_data", {20'd0, od}, 32'h2A5);
            chk("bp_pop",  {28'd0, pop}, 0);
        end
        @(posedge clk);
        #1;
        ordy = 1'b1;
        drain(200);

        // Dest mismatch, then saturation
        phase = 4;
        push(1, 12'h3FF);
        push(1, 12'h1A1);
        drain(200);
        chk("t4_drop", {24'd0, drop}, exp_drop);
        for (int k = 0; k < 300; k++)
            push(1, 12'h3FF);
        drain(2000);
        chk("t4_sat", {24'd0, drop}, exp_drop);

        // Skip ineligible FIFOs
        phase = 5;
        push(0, 12'h0C0);
        drain(200);
        push(2, 12'h2C1);
        push(0, 12'h0C1);
        push(2, 12'h2C2);
        push(0, 12'h0C2);
        drain(200);

        // Streaming rate and fwd_count wrap
        phase = 6;
        n = 258 - exp_fwd;
        for (int k = 0; k < n; k++)
            push(3, {4'h3, 8'(k)});
        drain(3000);
        chk("t6_fwd",  {24'd0, fwd}, exp_fwd);
        chk("t6_drop", {24'd0, drop}, exp_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
